// File: rtl/tx_sched_arbiter_if.sv
// Signal bundle for tx_sched_arbiter: requester byte streams, transmit line and register port.
// The requester side is the master and the arbiter is the slave.
interface tx_sched_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 tx_en;
   logic [7:0]           tx_data;
   logic [1:0]           cfg_addr;
   logic                 cfg_wr;
   logic [7:0]           cfg_wdata;
   logic                 cfg_rd;
   logic [7:0]           cfg_rdata;

   modport master (
      output req_valid, req_data, req_last, cfg_addr, cfg_wr, cfg_wdata, cfg_rd,
      input  req_ready, tx_en, tx_data, cfg_rdata
   );

   modport slave (
      input  req_valid, req_data, req_last, cfg_addr, cfg_wr, cfg_wdata, cfg_rd,
      output req_ready, tx_en, tx_data, cfg_rdata
   );
endinterface

// File: rtl/tx_sched_arbiter.sv
// Round-robin scheduler sharing one byte-wide transmit line among NUM_REQ packet requesters,
// with inter-packet gap, maximum grant length, packet counter and a small register port.
module tx_sched_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int MAX_LEN = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   tx_sched_arbiter_if.slave bus,
   output logic [1:0]        dbg_state
);
   localparam int         IDX_W    = $clog2(NUM_REQ);
   localparam logic [7:0] LAST_CNT = 8'(MAX_LEN - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_GAP = 2'd2} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   grant_q, ptr_q, pick, idx;
   logic               pick_found;
   logic [7:0]         byte_cnt_q, gap_cnt_q;
   logic               en_q, err_q;
   logic [NUM_REQ-1:0] mask_q, eligible;
   logic [7:0]         gap_q, pkt_cnt_q;
   logic               tx_en_q;
   logic [7:0]         tx_data_q, rdata_q, rd_mux, mask_rd;
   logic               sel_valid, sel_last, xfer, at_max, pkt_end, trunc;
   logic [7:0]         sel_data;

   // Handshake: a byte moves on a rising edge where req_valid[i] and req_ready[i] are both high;
   // ready depends only on state/grant, so a requester may not wait for ready before raising valid.
   assign eligible  = bus.req_valid & mask_q;
   assign sel_valid = bus.req_valid[grant_q];
   assign sel_last  = bus.req_last[grant_q];
   assign sel_data  = bus.req_data[{grant_q, 3'b000} +: 8];
   assign xfer      = (state_q == S_SEND) && sel_valid;
   assign at_max    = (byte_cnt_q == LAST_CNT);
   assign pkt_end   = xfer && (sel_last || at_max);
   assign trunc     = xfer && !sel_last && at_max;

   // First eligible requester after the last grant, wrapping around.
   always_comb begin
      pick       = '0;
      pick_found = 1'b0;
      idx        = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
         if (!pick_found && eligible[idx]) begin
            pick_found = 1'b1;
            pick       = idx;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      bus.req_ready = '0;
      unique case (state_q)
         S_IDLE: if (en_q && pick_found) state_d = S_SEND;
         S_SEND: begin
            bus.req_ready[grant_q] = 1'b1;
            if (pkt_end) state_d = (gap_q != 8'd0) ? S_GAP : S_IDLE;
         end
         S_GAP:  if (gap_cnt_q == 8'd0) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mask_rd               = '0;
      mask_rd[NUM_REQ-1:0]  = mask_q;
      rd_mux                = '0;
      unique case (bus.cfg_addr)
         2'd0: rd_mux = {5'b0, err_q, (state_q != S_IDLE), en_q};
         2'd1: rd_mux = mask_rd;
         2'd2: rd_mux = gap_q;
         2'd3: rd_mux = pkt_cnt_q;
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         grant_q    <= '0;
         ptr_q      <= IDX_W'(NUM_REQ - 1);
         byte_cnt_q <= '0;
         gap_cnt_q  <= '0;
         en_q       <= 1'b0;
         err_q      <= 1'b0;
         mask_q     <= '1;
         gap_q      <= '0;
         pkt_cnt_q  <= '0;
         tx_en_q    <= 1'b0;
         tx_data_q  <= '0;
         rdata_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && state_d == S_SEND) begin
            grant_q <= pick;
            ptr_q   <= pick;
         end
         if (pkt_end)   byte_cnt_q <= '0;
         else if (xfer) byte_cnt_q <= byte_cnt_q + 8'd1;
         // Gap length is latched at packet end so a GAP rewrite only affects later packets.
         if (pkt_end)                                    gap_cnt_q <= gap_q - 8'd1;
         else if (state_q == S_GAP && gap_cnt_q != 8'd0) gap_cnt_q <= gap_cnt_q - 8'd1;
         tx_en_q <= xfer;
         if (xfer) tx_data_q <= sel_data;
         if (bus.cfg_wr && bus.cfg_addr == 2'd0) en_q   <= bus.cfg_wdata[0];
         if (bus.cfg_wr && bus.cfg_addr == 2'd1) mask_q <= bus.cfg_wdata[NUM_REQ-1:0];
         if (bus.cfg_wr && bus.cfg_addr == 2'd2) gap_q  <= bus.cfg_wdata;
         if (trunc)                                                    err_q <= 1'b1;
         else if (bus.cfg_wr && bus.cfg_addr == 2'd0 && bus.cfg_wdata[2]) err_q <= 1'b0;
         if (bus.cfg_wr && bus.cfg_addr == 2'd3) pkt_cnt_q <= '0;
         else if (pkt_end)                       pkt_cnt_q <= pkt_cnt_q + 8'd1;
         if (bus.cfg_rd) rdata_q <= rd_mux;
      end
   end

   assign bus.tx_en     = tx_en_q;
   assign bus.tx_data   = tx_data_q;
   assign bus.cfg_rdata = rdata_q;
   assign dbg_state     = state_q;
endmodule

// File: tb/tb_tx_sched_arbiter.sv
// Directed bench for tx_sched_arbiter: one instance with MAX_LEN=64, one with MAX_LEN=4,
// requester queues as byte sources, transmit log checked against an expected queue.
module tb_tx_sched_arbiter;
   localparam int NR = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   tx_sched_arbiter_if #(.NUM_REQ(NR)) bus_a ();
   tx_sched_arbiter_if #(.NUM_REQ(NR)) bus_b ();
   logic [1:0] dbg_a, dbg_b;

   tx_sched_arbiter #(.NUM_REQ(NR), .MAX_LEN(64)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a), .dbg_state(dbg_a));
   tx_sched_arbiter #(.NUM_REQ(NR), .MAX_LEN(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b), .dbg_state(dbg_b));

   int chk_cnt = 0;
   int err_cnt = 0;
   int cyc = 0;

   logic [8:0]    src_q [2*NR][$];
   logic [NR-1:0] hold [2];
   logic [NR-1:0] prev_v [2];
   logic [NR-1:0] prev_r [2];
   logic [NR-1:0] ever_ready [2];
   int            log_cyc_a[$], log_cyc_b[$];
   logic [7:0]    log_byte_a[$], log_byte_b[$];
   logic [7:0]    exp_q[$];
   int            exp_cyc[$];

   // ---------------- checking ----------------
   task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver: one cycle ----------------
   logic [NR-1:0]   st_v, st_l, st_rdy;
   logic [8*NR-1:0] st_dat;
   logic [8:0]      st_head;

   task step();
      @(negedge clk);
      cyc++;
      if (bus_a.tx_en) begin log_cyc_a.push_back(cyc); log_byte_a.push_back(bus_a.tx_data); end
      if (bus_b.tx_en) begin log_cyc_b.push_back(cyc); log_byte_b.push_back(bus_b.tx_data); end
      for (int d = 0; d < 2; d++) begin
         st_rdy = (d == 0) ? bus_a.req_ready : bus_b.req_ready;
         ever_ready[d] |= st_rdy;
         st_v = '0; st_l = '0; st_dat = '0;
         for (int i = 0; i < NR; i++) begin
            if (prev_v[d][i] && prev_r[d][i] && src_q[d*NR+i].size() > 0)
               void'(src_q[d*NR+i].pop_front());
            if (src_q[d*NR+i].size() > 0 && !hold[d][i]) begin
               st_head          = src_q[d*NR+i][0];
               st_v[i]          = 1'b1;
               st_l[i]          = st_head[8];
               st_dat[i*8 +: 8] = st_head[7:0];
            end
         end
         prev_v[d] = st_v;
         prev_r[d] = st_rdy;
         if (d == 0) begin
            bus_a.req_valid = st_v; bus_a.req_last = st_l; bus_a.req_data = st_dat;
         end else begin
            bus_b.req_valid = st_v; bus_b.req_last = st_l; bus_b.req_data = st_dat;
         end
      end
   endtask

   task run(input int n);
      repeat (n) step();
   endtask

   task drive_cfg(input int d, input logic [1:0] a, input logic wr, input logic [7:0] wd,
                  input logic rd);
      if (d == 0) begin
         bus_a.cfg_addr = a; bus_a.cfg_wr = wr; bus_a.cfg_wdata = wd; bus_a.cfg_rd = rd;
      end else begin
         bus_b.cfg_addr = a; bus_b.cfg_wr = wr; bus_b.cfg_wdata = wd; bus_b.cfg_rd = rd;
      end
   endtask

   task cfg_write(input int d, input logic [1:0] a, input logic [7:0] v);
      drive_cfg(d, a, 1'b1, v, 1'b0);
      step();
      drive_cfg(d, 2'd0, 1'b0, 8'h00, 1'b0);
   endtask

   task cfg_read(input int d, input logic [1:0] a, output logic [7:0] v);
      drive_cfg(d, a, 1'b0, 8'h00, 1'b1);
      step();
      drive_cfg(d, 2'd0, 1'b0, 8'h00, 1'b0);
      v = (d == 0) ? bus_a.cfg_rdata : bus_b.cfg_rdata;
   endtask

   task read_check(input int d, input logic [1:0] a, input logic [7:0] exp, input string tag);
      logic [7:0] v;
      cfg_read(d, a, v);
      check(tag, v, exp);
   endtask

   // Queue a packet of n bytes base, base+1, ... for requester i of instance d.
   task push_pkt(input int d, input int i, input logic [7:0] base, input int n,
                 input logic with_last);
      for (int j = 0; j < n; j++)
         src_q[d*NR+i].push_back({with_last && (j == n - 1), base + 8'(j)});
   endtask

   task expect_bytes(input logic [7:0] base, input int n, input int first_cyc);
      for (int j = 0; j < n; j++) begin
         exp_q.push_back(base + 8'(j));
         if (first_cyc >= 0) exp_cyc.push_back(first_cyc + j);
      end
   endtask

   int         cl_n;
   logic [7:0] cl_b;
   int         cl_c;

   // Compare the transmit log of instance d with exp_q / exp_cyc, then clear all three.
   task check_log(input int d, input string tag);
      cl_n = (d == 0) ? log_byte_a.size() : log_byte_b.size();
      check({tag, "_count"}, cl_n, exp_q.size());
      for (int j = 0; j < cl_n && j < exp_q.size(); j++) begin
         cl_b = (d == 0) ? log_byte_a[j] : log_byte_b[j];
         cl_c = (d == 0) ? log_cyc_a[j] : log_cyc_b[j];
         check($sformatf("%s_byte%0d", tag, j), cl_b, exp_q[j]);
         if (j < exp_cyc.size()) check($sformatf("%s_cyc%0d", tag, j), cl_c, exp_cyc[j]);
      end
      exp_q.delete(); exp_cyc.delete();
      log_byte_a.delete(); log_cyc_a.delete(); log_byte_b.delete(); log_cyc_b.delete();
   endtask

   task reset_begin();
      rst_n = 1'b0;
      for (int k = 0; k < 2*NR; k++) src_q[k].delete();
      for (int d = 0; d < 2; d++) begin
         hold[d] = '0; prev_v[d] = '0; prev_r[d] = '0; ever_ready[d] = '0;
      end
      drive_cfg(0, 2'd0, 1'b0, 8'h00, 1'b0);
      drive_cfg(1, 2'd0, 1'b0, 8'h00, 1'b0);
      exp_q.delete(); exp_cyc.delete();
      log_byte_a.delete(); log_cyc_a.delete(); log_byte_b.delete(); log_cyc_b.delete();
   endtask

   task reset_end();
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task wait_log_a(input int n, input string tag);
      for (int w = 0; w < 40 && log_byte_a.size() < n; w++) step();
      check(tag, (log_byte_a.size() >= n), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n0;
   int st;
   logic [7:0] pk1 [10];

   initial begin
      pk1 = '{8'hDE, 8'hAD, 8'h05, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'hBE, 8'hEF};
      bus_a.req_valid = '0; bus_a.req_data = '0; bus_a.req_last = '0;
      bus_b.req_valid = '0; bus_b.req_data = '0; bus_b.req_last = '0;
      #1;
      reset_begin();
      step();
      check("rst_tx_en", bus_a.tx_en, 0);
      check("rst_tx_data", bus_a.tx_data, 0);
      check("rst_ready", bus_a.req_ready, 0);
      check("rst_rdata", bus_a.cfg_rdata, 0);
      reset_end();
      read_check(0, 2'd0, 8'h00, "rst_ctrl");
      read_check(0, 2'd1, 8'h0F, "rst_mask");
      read_check(0, 2'd2, 8'h00, "rst_gap");
      read_check(0, 2'd3, 8'h00, "rst_pkt");

      // 1: single 10-byte packet, GAP=0
      cfg_write(0, 2'd0, 8'h01);
      n0 = cyc + 1;
      for (int j = 0; j < 10; j++) begin
         src_q[0].push_back({(j == 9), pk1[j]});
         exp_q.push_back(pk1[j]);
         exp_cyc.push_back(n0 + 2 + j);
      end
      run(16);
      check_log(0, "t1");
      read_check(0, 2'd3, 8'h01, "t1_pkt");
      read_check(0, 2'd0, 8'h01, "t1_ctrl");
      drive_cfg(0, 2'd2, 1'b1, 8'h07, 1'b1);
      step();
      drive_cfg(0, 2'd0, 1'b0, 8'h00, 1'b0);
      check("t1_rd_wr_same", bus_a.cfg_rdata, 8'h00);
      read_check(0, 2'd2, 8'h07, "t1_gap_rb");

      // 2: all four requesters, 2-byte packets, GAP=3
      reset_begin(); reset_end();
      cfg_write(0, 2'd0, 8'h01);
      cfg_write(0, 2'd2, 8'h03);
      n0 = cyc + 1;
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < NR; i++) push_pkt(0, i, 8'(16*(i+1) + 2*p), 2, 1'b1);
      st = n0 + 2;
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < NR; i++) begin
            expect_bytes(8'(16*(i+1) + 2*p), 2, st);
            st = st + 6;
         end
      run(60);
      check_log(0, "t2");
      read_check(0, 2'd3, 8'h08, "t2_pkt");

      // 3: MASK=1010, all valid, GAP=0
      reset_begin(); reset_end();
      cfg_write(0, 2'd0, 8'h01);
      cfg_write(0, 2'd1, 8'h0A);
      ever_ready[0] = '0;
      n0 = cyc + 1;
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < NR; i++) push_pkt(0, i, 8'(16*(i+1) + 2*p), 2, 1'b1);
      st = n0 + 2;
      for (int p = 0; p < 2; p++) begin
         expect_bytes(8'(16*2 + 2*p), 2, st); st = st + 3;
         expect_bytes(8'(16*4 + 2*p), 2, st); st = st + 3;
      end
      run(25);
      check_log(0, "t3");
      check("t3_ready_seen", ever_ready[0], 4'b1010);
      read_check(0, 2'd3, 8'h04, "t3_pkt");

      // 4: MAX_LEN=4 instance, 6-byte packet truncated after 4
      reset_begin(); reset_end();
      cfg_write(1, 2'd0, 8'h01);
      n0 = cyc + 1;
      push_pkt(1, 0, 8'h11, 4, 1'b0);
      expect_bytes(8'h11, 4, n0 + 2);
      run(10);
      check_log(1, "t4a");
      read_check(1, 2'd0, 8'h05, "t4a_ctrl");
      read_check(1, 2'd3, 8'h01, "t4a_pkt");
      n0 = cyc + 1;
      push_pkt(1, 0, 8'h15, 2, 1'b1);
      expect_bytes(8'h15, 2, n0 + 2);
      run(8);
      check_log(1, "t4b");
      read_check(1, 2'd3, 8'h02, "t4b_pkt");
      read_check(1, 2'd0, 8'h05, "t4b_ctrl");
      cfg_write(1, 2'd0, 8'h04);
      read_check(1, 2'd0, 8'h00, "t4_err_clr");
      cfg_write(1, 2'd3, 8'hAA);
      read_check(1, 2'd3, 8'h00, "t4_pkt_clr");

      // 5a: requester 0 drops valid for 3 cycles mid-packet
      reset_begin(); reset_end();
      cfg_write(0, 2'd0, 8'h01);
      n0 = cyc + 1;
      push_pkt(0, 0, 8'h31, 6, 1'b1);
      push_pkt(0, 1, 8'h41, 2, 1'b1);
      expect_bytes(8'h31, 4, n0 + 2);
      expect_bytes(8'h35, 2, n0 + 9);
      expect_bytes(8'h41, 2, n0 + 12);
      wait_log_a(3, "t5a_wait");
      hold[0][0] = 1'b1;
      step();
      check("t5a_ready_held", bus_a.req_ready, 4'b0001);
      step();
      check("t5a_bubble", bus_a.tx_en, 0);
      check("t5a_grant_kept", bus_a.req_ready, 4'b0001);
      step();
      hold[0][0] = 1'b0;
      run(15);
      check_log(0, "t5a");

      // 5b: EN cleared mid-packet
      reset_begin(); reset_end();
      cfg_write(0, 2'd0, 8'h01);
      push_pkt(0, 0, 8'h51, 5, 1'b1);
      push_pkt(0, 1, 8'h61, 2, 1'b1);
      expect_bytes(8'h51, 5, -1);
      wait_log_a(2, "t5b_wait");
      cfg_write(0, 2'd0, 8'h00);
      run(15);
      check_log(0, "t5b");
      check("t5b_ready", bus_a.req_ready, 0);
      read_check(0, 2'd0, 8'h00, "t5b_ctrl");

      // 6: reset during byte 5 of a packet
      reset_begin(); reset_end();
      cfg_write(0, 2'd1, 8'h0B);
      cfg_write(0, 2'd2, 8'h05);
      cfg_write(0, 2'd0, 8'h01);
      push_pkt(0, 0, 8'h91, 8, 1'b1);
      expect_bytes(8'h91, 4, -1);
      wait_log_a(4, "t6_wait");
      rst_n = 1'b0;
      #1;
      check("t6_tx_en", bus_a.tx_en, 0);
      check("t6_tx_data", bus_a.tx_data, 0);
      check("t6_ready", bus_a.req_ready, 0);
      check("t6_state", dbg_a, 0);
      check_log(0, "t6_pre");
      reset_begin(); reset_end();
      check("t6_rdata", bus_a.cfg_rdata, 0);
      read_check(0, 2'd0, 8'h00, "t6_ctrl");
      read_check(0, 2'd1, 8'h0F, "t6_mask");
      read_check(0, 2'd2, 8'h00, "t6_gap");
      read_check(0, 2'd3, 8'h00, "t6_pkt");
      cfg_write(0, 2'd0, 8'h01);
      push_pkt(0, 0, 8'h71, 2, 1'b1);
      push_pkt(0, 1, 8'h81, 2, 1'b1);
      expect_bytes(8'h71, 2, -1);
      expect_bytes(8'h81, 2, -1);
      run(15);
      check_log(0, "t6_post");

      $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
      $finish;
   end
endmodule

// File: doc/tx_sched_arbiter.md
# tx_sched_arbiter

Round-robin scheduler that shares the single byte-wide transmit line (tx_en/tx_data) among NUM_REQ packet requesters. Each requester presents a packet as a valid/ready byte stream with a last flag; the block grants one requester at a time, forwards its bytes, enforces a programmable inter-packet gap and a maximum packet length, and counts packets. A small register port (addr/wr/rd, 8-bit data) configures and monitors it, and sits on the same config bus as the transmitter.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- MAX_LEN, 64: maximum bytes per grant (1..255).
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i has a byte on req_data[8i+7:8i].
- req_data  in  8*NUM_REQ  packed request bytes.
- req_last  in  NUM_REQ  byte is the last of its packet.
- req_ready  out  NUM_REQ  byte accepted this cycle when valid&ready.
- tx_en  out  1  tx_data carries a packet byte.
- tx_data  out  8  transmit byte.
- cfg_addr  in  2  register address.
- cfg_wr  in  1  write strobe.
- cfg_wdata  in  8  write data.
- cfg_rd  in  1  read strobe.
- cfg_rdata  out  8  read data, registered.

## Operation
- Registers: addr0 CTRL: bit0 EN (rw), bit1 BUSY (ro, state!=IDLE), bit2 ERR (sticky, write 1 clears), other bits read 0. addr1 MASK[NUM_REQ-1:0] (rw, 1=requester eligible). addr2 GAP[7:0] (rw). addr3 PKT_CNT[7:0] (ro, any write clears).
- Reset values: EN=0, MASK=all ones, GAP=0, PKT_CNT=0, ERR=0, last-grant pointer=NUM_REQ-1, state IDLE.
- FSM states IDLE, SEND, GAP.
- IDLE: if EN=1 and (req_valid & MASK)!=0, pick first eligible index searching from pointer+1 upward with wrap; register grant, pointer<=grant, go SEND. Else stay.
- SEND: req_ready[grant]=1, all other ready bits 0 (ready is combinational from state/grant). On transfer: tx_data<=byte, tx_en<=1, byte counter++. Cycles with no transfer: tx_en<=0 (bubble; grant held).
- End of grant: transfer with req_last=1, or the transfer that makes byte counter = MAX_LEN with req_last=0 (then ERR<=1). On end: PKT_CNT++ (mod 256), counter<=0, go GAP if GAP>0 else IDLE.
- GAP: count GAP cycles, then IDLE. No ready asserted.
- EN or MASK changes mid-SEND/GAP do not abort; they affect the next arbitration only.
- Truncated packet remainder is treated as a new packet at the requester's next grant.
- PKT_CNT clear write coincident with packet end: result 0. ERR clear coincident with new error: ERR=1.
- Config write to CTRL/MASK/GAP takes effect the cycle after the write.
- Reset asserted mid-packet: all state returns to reset values immediately; tx_en=0, req_ready=0; partial packet is dropped.

## Timing
- Reset value of outputs: tx_en=0, tx_data=0, req_ready=0, cfg_rdata=0.
- Grant latency: eligible valid seen in IDLE at edge t -> SEND from t+1, ready high in cycle t+1; first byte on tx_data in cycle t+2.
- Byte latency: transfer at cycle k -> tx_en/tx_data in cycle k+1.
- Gap: last byte on tx in cycle m -> next packet's first byte no earlier than m+GAP+2 (GAP=0 gives one idle tx cycle).
- cfg_rdata valid the cycle after cfg_rd, holds until next read; read and write same address same cycle returns pre-write value.
- Throughput: one byte per cycle within a packet when valid stays high.

## Test plan
- Single requester 0, EN=1, 10-byte packet DE AD 05 10 20 30 40 50 BE EF, GAP=0 -> tx_en high 10 consecutive cycles starting 2 cycles after valid, bytes in order, PKT_CNT reads 1.
- All 4 requesters continuously valid, 2-byte packets, GAP=3 -> grant order 0,1,2,3,0; 4 idle tx cycles between packets.
- MASK=4'b1010, all valid -> only requesters 1 and 3 ever see ready; alternate 1,3,1.
- MAX_LEN=4, 6-byte packet -> 4 bytes sent, ERR=1, PKT_CNT=1; remaining 2 bytes sent as next packet, PKT_CNT=2; write 0x04 to addr0 clears ERR.
- Requester drops valid for 3 cycles mid-packet -> tx_en low 3 cycles, grant held, no other requester served; EN cleared mid-packet -> packet completes, no further grant, BUSY=0.
- Assert rst_n=0 during byte 5 of a packet -> tx_en, req_ready 0 same cycle; registers read reset values; after release first grant goes to requester 0.
